// File: rtl/iterative_divider_pkg.sv
// Shared types for the iterative divider: FSM states, status bit
// positions and the step counter width helper.
package iterative_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_SIGN,
      ST_DONE
   } div_state_e;

   localparam int STATUS_DIV0 = 0;
   localparam int STATUS_OVF  = 1;

   // Counter must hold step indices 0..n-1.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/N_bit_adder.sv
// Ripple-carry adder: sum/cout = a + b + cin.
// Ports: a, b (N), cin (1) -> sum (N), cout (1).
module N_bit_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   always_comb begin
      c   = '0;
      sum = '0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[N];
   end

endmodule

// File: rtl/iterative_divider_div_step.sv
// One combinational restoring-division step.
// Ports: r_i/q_i/d_i (N) partial remainder, quotient, divisor -> r_o, q_o.
module div_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] r_i,
   input  logic [N-1:0] q_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] r_o,
   output logic [N-1:0] q_o
);

   // Stored remainder is always below the divisor, so only the shifted
   // value needs the extra top bit.
   logic [N:0]   r_sh;
   logic [N-1:0] diff;
   logic         cout;
   logic         take;

   assign r_sh = {r_i, q_i[N-1]};

   N_bit_adder #(.N(N)) u_sub (
      .a   (r_sh[N-1:0]),
      .b   (~d_i),
      .cin (1'b1),
      .sum (diff),
      .cout(cout)
   );

   // trial[N] = r_sh[N] ^ 1 ^ cout; the step succeeds when it is zero.
   assign take = r_sh[N] ^ cout;
   assign r_o  = take ? diff : r_sh[N-1:0];
   assign q_o  = {q_i[N-2:0], take};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// Ports: start/flush/signed_op, dividend/divisor in; busy/done, quotient/remainder/status out.
module iterative_divider
   import iterative_divider_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         flush,
   input  logic         signed_op,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic [1:0]   status
);

   localparam int CW = cnt_w(N);
   localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

   div_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
   logic         neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic [N-1:0] quot_q, quot_d, rem_q, rem_d;
   logic [1:0]   stat_q, stat_d;
   logic [N-1:0] r_step, q_step;

   div_step #(.N(N)) u_step (
      .r_i(r_q),
      .q_i(q_q),
      .d_i(d_q),
      .r_o(r_step),
      .q_o(q_step)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      stat_d  = stat_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  neg_r_d = signed_op & dividend[N-1];
                  neg_q_d = signed_op & (dividend[N-1] ^ divisor[N-1]);
                  if (divisor == '0) begin
                     quot_d  = '1;
                     rem_d   = dividend;
                     stat_d  = '0;
                     stat_d[STATUS_DIV0] = 1'b1;
                     state_d = ST_DONE;
                  end else if (signed_op && dividend == INT_MIN
                               && divisor == '1) begin
                     quot_d  = dividend;
                     rem_d   = '0;
                     stat_d  = '0;
                     stat_d[STATUS_OVF] = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     q_d = (signed_op && dividend[N-1]) ? -dividend : dividend;
                     d_d = (signed_op && divisor[N-1]) ? -divisor : divisor;
                     r_d     = '0;
                     cnt_d   = '0;
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_d   = r_step;
               q_d   = q_step;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) state_d = ST_SIGN;
            end
            ST_SIGN: begin
               quot_d  = neg_q_q ? -q_q : q_q;
               rem_d   = neg_r_q ? -r_q : r_q;
               stat_d  = '0;
               state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         stat_q  <= stat_d;
      end
   end

   assign busy      = (state_q == ST_CALC) || (state_q == ST_SIGN);
   assign done      = (state_q == ST_DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign status    = stat_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Randomized + directed bench for iterative_divider against an
// arithmetic reference model.
module tb_iterative_divider;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic         signed_op = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         busy, done;
   logic [N-1:0] quotient, remainder;
   logic [1:0]   status;

   int n_chk = 0;
   int n_pass = 0;

   iterative_divider #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .flush    (flush),
      .signed_op(signed_op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .status   (status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, output logic [N-1:0] q,
                        output logic [N-1:0] r, output logic [1:0] st,
                        output int lat);
      logic signed [N-1:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) begin
         q = '1; r = a; st = 2'b01; lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = '0; st = 2'b10; lat = 1;
      end else if (s) begin
         q = sa / sb; r = sa % sb; st = 2'b00; lat = N + 2;
      end else begin
         q = a / b; r = a % b; st = 2'b00; lat = N + 2;
      end
   endtask

   // inj_at > 0 pulses start with other operands after that many edges.
   task automatic run_div(input string tag, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic s,
                          input int inj_at);
      logic [N-1:0] eq, er;
      logic [1:0]   est;
      int           elat, edges, bc;
      model(a, b, s, eq, er, est, elat);
      @(negedge clk);
      dividend = a; divisor = b; signed_op = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      bc = 0;
      while (!done && edges < 100) begin
         if (busy) bc++;
         if (edges == inj_at) begin
            dividend = ~a; divisor = b + 3; signed_op = ~s; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         edges++;
      end
      start = 1'b0;
      chk({tag, " latency"}, edges, elat);
      chk({tag, " quot"}, quotient, eq);
      chk({tag, " rem"}, remainder, er);
      chk({tag, " status"}, status, est);
      chk({tag, " busy_cycles"}, bc, (elat == 1) ? 0 : N + 1);
      chk({tag, " busy_at_done"}, busy, 0);
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " quot_held"}, quotient, eq);
   endtask

   initial begin
      logic [N-1:0] a, b;
      logic         s;
      int           seen;

      #12;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst quot", quotient, 0);
      chk("rst rem", remainder, 0);
      chk("rst status", status, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_div("u100_7", 100, 7, 1'b0, 0);
      run_div("s-7_2", 32'hFFFF_FFF9, 2, 1'b1, 0);
      run_div("s7_-2", 7, 32'hFFFF_FFFE, 1'b1, 0);
      run_div("s5_0", 5, 0, 1'b1, 0);
      run_div("u5_0", 5, 0, 1'b0, 0);
      run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_div("u_ovfops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_div("start_ign", 100, 7, 1'b0, 5);

      // flush after step 10 of 100/7
      @(negedge clk);
      dividend = 100; divisor = 7; signed_op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush busy", busy, 0);
      chk("flush no_done", seen | done, 0);
      chk("flush quot_kept", quotient, 14);
      run_div("after_flush", 9, 3, 1'b0, 0);

      // async reset mid-CALC
      @(negedge clk);
      dividend = 1000; divisor = 9; signed_op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst busy", busy, 0);
      chk("arst done", done, 0);
      chk("arst quot", quotient, 0);
      chk("arst rem", remainder, 0);
      chk("arst status", status, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div("after_rst", 1000, 9, 1'b0, 0);

      for (int k = 0; k < 40; k++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         if (k % 4 == 0) b = $urandom_range(0, 15);
         if (k % 3 == 0) b = b >> $urandom_range(0, 31);
         if (k % 9 == 0) begin
            a = 32'h8000_0000; b = 32'hFFFF_FFFF;
         end
         run_div($sformatf("rnd%0d", k), a, b, s, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
